// File: rtl/fios_operand_feeder.sv
// Operand staging and result collection around the FIOS Montgomery multiplier.
// Buffers host-loaded a/b/p operands and turns multiplier result pushes into a host stream.
module fios_operand_feeder #(
    parameter int unsigned s     = 8,
    parameter int unsigned PE_NB = 8
) (
    input  logic                  clock_i,
    input  logic                  reset_i,
    input  logic                  load_valid_i,
    input  logic [1:0]            load_sel_i,
    input  logic [16:0]           load_data_i,
    output logic                  load_ready_o,
    input  logic                  start_i,
    output logic                  mm_start_o,
    input  logic                  a_shift_i,
    input  logic                  b_fetch_i,
    input  logic                  p_fetch_i,
    output logic [PE_NB*17-1:0]   a_o,
    output logic [16:0]           b_o,
    output logic [16:0]           p_o,
    input  logic                  res_push_i,
    input  logic [16:0]           res_i,
    input  logic                  done_i,
    output logic                  res_valid_o,
    output logic [16:0]           res_data_o,
    output logic                  res_last_o,
    output logic                  busy_o,
    output logic                  done_o
);

    localparam int unsigned W  = 17;
    localparam int unsigned AW = (s > 1) ? $clog2(s) : 1;
    localparam int unsigned IW = $clog2(s) + 1;

    typedef enum logic [1:0] {StIdle, StPrime, StRun, StDrain} state_e;

    state_e              state_q;
    logic [W-1:0]        mem_a [s];
    logic [W-1:0]        mem_b [s];
    logic [W-1:0]        mem_p [s];
    logic [IW-1:0]       idx_a_q, idx_b_q, idx_p_q;
    logic                full_a_q, full_b_q, full_p_q;
    logic [IW-1:0]       group_q;
    logic [AW-1:0]       bptr_q, pptr_q;
    logic [IW-1:0]       res_cnt_q;
    logic [PE_NB*W-1:0]  a_q;
    logic [W-1:0]        b_q, p_q, res_data_q;
    logic                load_ready_q, mm_start_q, res_valid_q, res_last_q, busy_q, done_q;

    logic                load_acc;
    logic                all_full;
    logic                active;
    logic [PE_NB*W-1:0]  a_group;

    assign load_acc = (state_q == StIdle) && load_valid_i;
    assign all_full = full_a_q && full_b_q && full_p_q;
    assign active   = (state_q == StRun) || (state_q == StDrain);

    function automatic logic [AW-1:0] ptr_next(input logic [AW-1:0] ptr);
        return (ptr == AW'(s - 1)) ? '0 : ptr + 1'b1;
    endfunction

    // Group 0 while idle (priming), otherwise the group after the one on a_o.
    always_comb begin
        int unsigned base;
        int unsigned idx;
        a_group = '0;
        base    = (state_q == StIdle) ? 0 : 32'(group_q) * PE_NB;
        for (int unsigned j = 0; j < PE_NB; j++) begin
            idx = base + j;
            if (idx < s) begin
                a_group[j*W +: W] = mem_a[idx[AW-1:0]];
            end
        end
    end

    // Operand storage carries no reset; contents are qualified by the full flags.
    always_ff @(posedge clock_i) begin
        if (load_acc) begin
            unique case (load_sel_i)
                2'd0:    mem_a[idx_a_q[AW-1:0]] <= load_data_i;
                2'd1:    mem_b[idx_b_q[AW-1:0]] <= load_data_i;
                2'd2:    mem_p[idx_p_q[AW-1:0]] <= load_data_i;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q      <= StIdle;
            idx_a_q      <= '0;
            idx_b_q      <= '0;
            idx_p_q      <= '0;
            full_a_q     <= 1'b0;
            full_b_q     <= 1'b0;
            full_p_q     <= 1'b0;
            group_q      <= '0;
            bptr_q       <= '0;
            pptr_q       <= '0;
            res_cnt_q    <= '0;
            a_q          <= '0;
            b_q          <= '0;
            p_q          <= '0;
            res_data_q   <= '0;
            load_ready_q <= 1'b1;
            mm_start_q   <= 1'b0;
            res_valid_q  <= 1'b0;
            res_last_q   <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            mm_start_q  <= 1'b0;
            res_valid_q <= 1'b0;
            res_last_q  <= 1'b0;
            done_q      <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (load_acc) begin
                        unique case (load_sel_i)
                            2'd0: begin
                                if (idx_a_q == IW'(s - 1)) begin
                                    idx_a_q  <= '0;
                                    full_a_q <= 1'b1;
                                end else begin
                                    idx_a_q <= idx_a_q + 1'b1;
                                end
                            end
                            2'd1: begin
                                if (idx_b_q == IW'(s - 1)) begin
                                    idx_b_q  <= '0;
                                    full_b_q <= 1'b1;
                                end else begin
                                    idx_b_q <= idx_b_q + 1'b1;
                                end
                            end
                            2'd2: begin
                                if (idx_p_q == IW'(s - 1)) begin
                                    idx_p_q  <= '0;
                                    full_p_q <= 1'b1;
                                end else begin
                                    idx_p_q <= idx_p_q + 1'b1;
                                end
                            end
                            default: ;
                        endcase
                    end
                    if (start_i && all_full) begin
                        a_q          <= a_group;
                        b_q          <= mem_b[0];
                        p_q          <= mem_p[0];
                        group_q      <= IW'(1);
                        bptr_q       <= ptr_next('0);
                        pptr_q       <= ptr_next('0);
                        res_cnt_q    <= '0;
                        mm_start_q   <= 1'b1;
                        load_ready_q <= 1'b0;
                        state_q      <= StPrime;
                    end
                end
                StPrime: begin
                    busy_q  <= 1'b1;
                    state_q <= StRun;
                end
                StRun, StDrain: begin
                    if (a_shift_i) begin
                        a_q <= a_group;
                        // Saturate: once past s every further group reads as zeros anyway.
                        if (group_q != IW'(s)) begin
                            group_q <= group_q + 1'b1;
                        end
                    end
                    if (b_fetch_i) begin
                        b_q    <= mem_b[bptr_q];
                        bptr_q <= ptr_next(bptr_q);
                    end
                    if (p_fetch_i) begin
                        p_q    <= mem_p[pptr_q];
                        pptr_q <= ptr_next(pptr_q);
                    end
                    if (res_push_i && (res_cnt_q < IW'(s))) begin
                        res_data_q  <= res_i;
                        res_valid_q <= 1'b1;
                        res_last_q  <= (res_cnt_q == IW'(s - 1));
                        res_cnt_q   <= res_cnt_q + 1'b1;
                    end
                    if (state_q == StDrain) begin
                        full_a_q     <= 1'b0;
                        full_b_q     <= 1'b0;
                        full_p_q     <= 1'b0;
                        busy_q       <= 1'b0;
                        load_ready_q <= 1'b1;
                        state_q      <= StIdle;
                    end else if (done_i) begin
                        done_q  <= 1'b1;
                        state_q <= StDrain;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign load_ready_o = load_ready_q;
    assign mm_start_o   = mm_start_q;
    assign a_o          = a_q;
    assign b_o          = b_q;
    assign p_o          = p_q;
    assign res_valid_o  = res_valid_q;
    assign res_data_o   = res_data_q;
    assign res_last_o   = res_last_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;

endmodule

// File: tb/tb_fios_operand_feeder.sv
// Scoreboard bench for fios_operand_feeder: driver pushes expectations from a
// behavioural model, monitors pop and compare when the DUT presents outputs.
module tb_fios_operand_feeder;

    localparam int unsigned S  = 8;
    localparam int unsigned PE = 3;

    typedef struct packed {
        logic [PE*17-1:0] a;
        logic [16:0]      b;
        logic [16:0]      p;
    } ops_t;

    typedef struct packed {
        logic [16:0] d;
        logic        last;
    } res_t;

    logic             clk = 1'b0;
    logic             reset_i;
    logic             load_valid_i;
    logic [1:0]       load_sel_i;
    logic [16:0]      load_data_i;
    logic             load_ready_o;
    logic             start_i;
    logic             mm_start_o;
    logic             a_shift_i, b_fetch_i, p_fetch_i;
    logic [PE*17-1:0] a_o;
    logic [16:0]      b_o, p_o;
    logic             res_push_i;
    logic [16:0]      res_i;
    logic             done_i;
    logic             res_valid_o;
    logic [16:0]      res_data_o;
    logic             res_last_o;
    logic             busy_o;
    logic             done_o;

    fios_operand_feeder #(.s(S), .PE_NB(PE)) dut (
        .clock_i      (clk),
        .reset_i      (reset_i),
        .load_valid_i (load_valid_i),
        .load_sel_i   (load_sel_i),
        .load_data_i  (load_data_i),
        .load_ready_o (load_ready_o),
        .start_i      (start_i),
        .mm_start_o   (mm_start_o),
        .a_shift_i    (a_shift_i),
        .b_fetch_i    (b_fetch_i),
        .p_fetch_i    (p_fetch_i),
        .a_o          (a_o),
        .b_o          (b_o),
        .p_o          (p_o),
        .res_push_i   (res_push_i),
        .res_i        (res_i),
        .done_i       (done_i),
        .res_valid_o  (res_valid_o),
        .res_data_o   (res_data_o),
        .res_last_o   (res_last_o),
        .busy_o       (busy_o),
        .done_o       (done_o)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [16:0] ma [S];
    logic [16:0] mb [S];
    logic [16:0] mp [S];
    int          li [3];
    bit          full [3];
    int          gcur, bcur, pcur, rcnt;

    ops_t q_start [$];
    ops_t q_op [$];
    res_t q_res [$];

    int n_chk  = 0;
    int n_fail = 0;
    logic op_chk = 1'b0;
    logic op_due = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic ops_t model_ops();
        ops_t o;
        int   k;
        o.a = '0;
        for (int j = 0; j < int'(PE); j++) begin
            k = gcur * int'(PE) + j;
            if (k < int'(S)) o.a[j*17 +: 17] = ma[k];
        end
        o.b = mb[bcur];
        o.p = mp[pcur];
        return o;
    endfunction

    // Monitors
    always @(posedge clk) op_due <= op_chk;

    always @(negedge clk) begin
        ops_t e;
        res_t r;
        if (mm_start_o === 1'b1) begin
            if (q_start.size() == 0) begin
                check("start_unexpected", 64'd1, 64'd0);
            end else begin
                e = q_start.pop_front();
                check("start_a", 64'(a_o), 64'(e.a));
                check("start_b", 64'(b_o), 64'(e.b));
                check("start_p", 64'(p_o), 64'(e.p));
            end
        end
        if (op_due) begin
            if (q_op.size() == 0) begin
                check("op_no_expect", 64'd1, 64'd0);
            end else begin
                e = q_op.pop_front();
                check("strobe_a", 64'(a_o), 64'(e.a));
                check("strobe_b", 64'(b_o), 64'(e.b));
                check("strobe_p", 64'(p_o), 64'(e.p));
            end
        end
        if (res_valid_o === 1'b1) begin
            if (q_res.size() == 0) begin
                check("res_unexpected", 64'(res_data_o), 64'hdead);
            end else begin
                r = q_res.pop_front();
                check("res_data", 64'(res_data_o), 64'(r.d));
                check("res_last", 64'(res_last_o), 64'(r.last));
            end
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int sel, input logic [16:0] d);
        load_valid_i = 1'b1;
        load_sel_i   = 2'(sel);
        load_data_i  = d;
        case (sel)
            0: ma[li[0]] = d;
            1: mb[li[1]] = d;
            2: mp[li[2]] = d;
            default: ;
        endcase
        if (sel < 3) begin
            li[sel]++;
            if (li[sel] == int'(S)) begin
                li[sel]   = 0;
                full[sel] = 1'b1;
            end
        end
        cycle();
        load_valid_i = 1'b0;
    endtask

    task automatic try_start();
        bit ok;
        ok = full[0] && full[1] && full[2];
        start_i = 1'b1;
        if (ok) begin
            gcur = 0; bcur = 0; pcur = 0; rcnt = 0;
            q_start.push_back(model_ops());
        end
        cycle();
        start_i = 1'b0;
        if (ok) check("prime_ready", 64'(load_ready_o), 64'd0);
        else check("ignored_ready", 64'(load_ready_o), 64'd1);
        cycle();
        if (ok) check("run_busy", 64'(busy_o), 64'd1);
        else check("ignored_busy", 64'(busy_o), 64'd0);
    endtask

    task automatic step(input bit sh, input bit bf, input bit pf, input bit push,
                        input logic [16:0] d, input bit dn);
        res_t r;
        a_shift_i  = sh;
        b_fetch_i  = bf;
        p_fetch_i  = pf;
        res_push_i = push;
        res_i      = d;
        done_i     = dn;
        if (sh || bf || pf) begin
            if (sh) gcur++;
            if (bf) bcur = (bcur + 1) % int'(S);
            if (pf) pcur = (pcur + 1) % int'(S);
            q_op.push_back(model_ops());
            op_chk = 1'b1;
        end
        if (push) begin
            if (rcnt < int'(S)) begin
                r.d    = d;
                r.last = (rcnt == int'(S) - 1);
                q_res.push_back(r);
            end
            rcnt++;
        end
        cycle();
        a_shift_i = 1'b0; b_fetch_i = 1'b0; p_fetch_i = 1'b0;
        res_push_i = 1'b0; done_i = 1'b0; op_chk = 1'b0;
    endtask

    task automatic end_run(input bit push, input logic [16:0] d);
        step(1'b0, 1'b0, 1'b0, push, d, 1'b1);
        check("done_pulse", 64'(done_o), 64'd1);
        check("drain_busy", 64'(busy_o), 64'd1);
        check("drain_ready", 64'(load_ready_o), 64'd0);
        cycle();
        check("done_clear", 64'(done_o), 64'd0);
        check("ready_back", 64'(load_ready_o), 64'd1);
        check("idle_busy", 64'(busy_o), 64'd0);
        for (int k = 0; k < 3; k++) full[k] = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_a"}, 64'(a_o), 64'd0);
        check({tag, "_b"}, 64'(b_o), 64'd0);
        check({tag, "_p"}, 64'(p_o), 64'd0);
        check({tag, "_rdata"}, 64'(res_data_o), 64'd0);
        check({tag, "_ready"}, 64'(load_ready_o), 64'd1);
        check({tag, "_mmstart"}, 64'(mm_start_o), 64'd0);
        check({tag, "_rvalid"}, 64'(res_valid_o), 64'd0);
        check({tag, "_rlast"}, 64'(res_last_o), 64'd0);
        check({tag, "_busy"}, 64'(busy_o), 64'd0);
        check({tag, "_done"}, 64'(done_o), 64'd0);
    endtask

    function automatic bit rbit();
        return $urandom_range(0, 1) == 1;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_i = 1'b1; load_valid_i = 1'b0; load_sel_i = 2'd0; load_data_i = '0;
        start_i = 1'b0; a_shift_i = 1'b0; b_fetch_i = 1'b0; p_fetch_i = 1'b0;
        res_push_i = 1'b0; res_i = '0; done_i = 1'b0;
        for (int k = 0; k < 3; k++) begin li[k] = 0; full[k] = 1'b0; end
        gcur = 0; bcur = 0; pcur = 0; rcnt = 0;
        repeat (3) cycle();
        check_reset_values("rst");
        reset_i = 1'b0;
        cycle();

        // Directed: a=1..8, b=10..17, start refused until p is loaded
        for (int i = 0; i < int'(S); i++) load(0, 17'(i + 1));
        for (int i = 0; i < int'(S); i++) load(1, 17'(i + 10));
        load(3, 17'h1abcd);
        try_start();
        for (int i = 0; i < int'(S); i++) load(2, 17'(i + 20));
        try_start();
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b0, 1'b0, '0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0, '0, 1'b0);
        for (int i = 0; i < 9; i++) step(1'b0, 1'b0, 1'b0, 1'b1, 17'(32'h100 + i), 1'b0);
        end_run(1'b0, '0);
        try_start();

        // Randomized rounds; the last one is cut short by a reset mid-run
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 30; i++) load($urandom_range(0, 3), 17'($urandom));
            for (int k = 0; k < 3; k++) begin
                for (int i = 0; i < 2 * int'(S) && !full[k]; i++) load(k, 17'($urandom));
            end
            try_start();
            if (r < 2) begin
                for (int i = 0; i < 200 && rcnt < int'(S) - 1; i++)
                    step(rbit(), rbit(), rbit(), rbit(), 17'($urandom), 1'b0);
                end_run(1'b1, 17'($urandom));
            end else begin
                for (int i = 0; i < 200 && rcnt < 3; i++)
                    step(rbit(), rbit(), rbit(), rbit(), 17'($urandom), 1'b0);
                reset_i = 1'b1;
                cycle();
                check_reset_values("midrst");
                reset_i = 1'b0;
                for (int k = 0; k < 3; k++) begin li[k] = 0; full[k] = 1'b0; end
                try_start();
            end
        end

        repeat (3) cycle();
        check("start_q_empty", 64'(q_start.size()), 64'd0);
        check("op_q_empty", 64'(q_op.size()), 64'd0);
        check("res_q_empty", 64'(q_res.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
